// File: rtl/rr_grant_sequencer_if.sv
// Request/grant bundle between the requesters and the round-robin grant sequencer.
// The master side drives requests and release; the slave side (the arbiter) drives the grant flags.
interface rr_grant_sequencer_if;
    logic [3:0] i_req;
    logic       i_release;
    logic [1:0] o_grant_idx;
    logic       o_grant_valid;
    logic       o_grant_new;
    logic       o_timeout;

    modport master (
        output i_req,
        output i_release,
        input  o_grant_idx,
        input  o_grant_valid,
        input  o_grant_new,
        input  o_timeout
    );

    modport slave (
        input  i_req,
        input  i_release,
        output o_grant_idx,
        output o_grant_valid,
        output o_grant_new,
        output o_timeout
    );
endinterface

// File: rtl/rr_grant_sequencer.sv
// Four-way round-robin arbiter producing a registered grant index for a 2-to-4 decoder.
// A grant persists until release, requester drop, or the optional hold limit forces rotation.
module rr_grant_sequencer #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_grant_sequencer_if.slave  bus
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic             HOLD_EN  = (HOLD_MAX != 0);
    localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_MAX);

    state_t           r_state;
    state_t           w_state_next;
    logic [1:0]       r_ptr;
    logic [1:0]       w_ptr_next;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_cnt_next;
    logic [1:0]       r_grant_idx;
    logic [1:0]       w_grant_idx_next;
    logic             r_grant_valid;
    logic             w_grant_valid_next;
    logic             r_grant_new;
    logic             w_grant_new_next;
    logic             r_timeout;
    logic             w_timeout_next;

    logic [3:0]       w_req_rot;
    logic             w_any_req;
    logic [1:0]       w_win_ofs;
    logic [1:0]       w_winner;
    logic             w_end_rel;
    logic             w_end_drop;
    logic             w_end_hold;
    logic             w_cnt_sat;

    // Requests rotated so that bit 0 is the channel currently holding top priority.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            logic [1:0] w_src;
            assign w_src         = r_ptr + 2'(gi);
            assign w_req_rot[gi] = bus.i_req[w_src];
        end
    endgenerate

    assign w_any_req = |bus.i_req;

    always_comb begin
        w_win_ofs = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_win_ofs = 2'(i);
            end
        end
    end

    assign w_winner = r_ptr + w_win_ofs;

    assign w_end_rel  = bus.i_release;
    assign w_end_drop = ~bus.i_req[r_grant_idx];
    assign w_end_hold = HOLD_EN && (r_hold_cnt == HOLD_VAL);
    assign w_cnt_sat  = &r_hold_cnt;

    always_comb begin
        w_state_next       = r_state;
        w_ptr_next         = r_ptr;
        w_hold_cnt_next    = r_hold_cnt;
        w_grant_idx_next   = r_grant_idx;
        w_grant_valid_next = r_grant_valid;
        w_grant_new_next   = 1'b0;
        w_timeout_next     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_next       = ST_GRANT;
                    w_grant_idx_next   = w_winner;
                    w_grant_valid_next = 1'b1;
                    w_grant_new_next   = 1'b1;
                    w_ptr_next         = w_winner + 2'd1;
                    w_hold_cnt_next    = CNT_W'(1);
                end
            end
            ST_GRANT: begin
                if (w_end_rel || w_end_drop || w_end_hold) begin
                    w_state_next       = ST_IDLE;
                    w_grant_valid_next = 1'b0;
                    // A voluntary end on the same edge as the limit is not a timeout.
                    w_timeout_next     = w_end_hold && !w_end_rel && !w_end_drop;
                end else if (!w_cnt_sat) begin
                    w_hold_cnt_next = r_hold_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next       = ST_IDLE;
                w_grant_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_ptr         <= 2'd0;
            r_hold_cnt    <= '0;
            r_grant_idx   <= 2'd0;
            r_grant_valid <= 1'b0;
            r_grant_new   <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_ptr         <= w_ptr_next;
            r_hold_cnt    <= w_hold_cnt_next;
            r_grant_idx   <= w_grant_idx_next;
            r_grant_valid <= w_grant_valid_next;
            r_grant_new   <= w_grant_new_next;
            r_timeout     <= w_timeout_next;
        end
    end

    assign bus.o_grant_idx   = r_grant_idx;
    assign bus.o_grant_valid = r_grant_valid;
    assign bus.o_grant_new   = r_grant_new;
    assign bus.o_timeout     = r_timeout;

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Directed and randomized bench for rr_grant_sequencer against a grant-level reference model.
// The model tracks holder, priority pointer and cycles held, derived from the arbitration rules.
module tb_rr_grant_sequencer;

    localparam int HOLD = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rr_grant_sequencer_if bus();

    rr_grant_sequencer #(.HOLD_MAX(HOLD), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: who holds the grant, for how long, and who is next in line.
    bit m_valid, m_new, m_timeout;
    int m_idx, m_ptr, m_held;

    task automatic model_reset();
        m_valid = 0; m_new = 0; m_timeout = 0;
        m_idx = 0; m_ptr = 0; m_held = 0;
    endtask

    task automatic model_edge(input logic [3:0] rq, input logic rl);
        bit found;
        bit r, d, h;
        if (!m_valid) begin
            m_new = 0; m_timeout = 0;
            found = 0;
            for (int k = 0; k < 4; k++) begin
                if (!found && rq[(m_ptr + k) % 4]) begin
                    found = 1;
                    m_idx = (m_ptr + k) % 4;
                end
            end
            if (found) begin
                m_valid = 1; m_new = 1; m_held = 1;
                m_ptr = (m_idx + 1) % 4;
            end
        end else begin
            r = rl;
            d = !rq[m_idx];
            h = (m_held == HOLD);
            m_new = 0;
            if (r || d || h) begin
                m_valid = 0;
                m_timeout = h && !r && !d;
            end else begin
                m_held++;
                m_timeout = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag);
        chk({tag, "_idx"},   4'(bus.o_grant_idx),   4'(m_idx));
        chk({tag, "_valid"}, 4'(bus.o_grant_valid), 4'(m_valid));
        chk({tag, "_new"},   4'(bus.o_grant_new),   4'(m_new));
        chk({tag, "_tmo"},   4'(bus.o_timeout),     4'(m_timeout));
    endtask

    task automatic step(input string tag);
        logic [3:0] rq;
        logic       rl;
        @(posedge clk);
        rq = bus.i_req;
        rl = bus.i_release;
        if (!rst_n) model_reset();
        else        model_edge(rq, rl);
        #1;
        check_dut(tag);
        if (bus.o_grant_new)
            $display("[TB] %s: grant ch%0d at t=%0t", tag, bus.o_grant_idx, $time);
        if (bus.o_timeout)
            $display("[TB] %s: timeout at t=%0t", tag, $time);
    endtask

    // Pulse release during each grant's second cycle.
    function automatic logic rel_rule();
        return m_valid && (m_held == 2);
    endfunction

    int got[$];
    int exp_rot[5]    = '{0, 1, 2, 3, 0};
    int exp_sparse[3] = '{1, 3, 1};
    int n;
    bit seen;

    initial begin
        bus.i_req     = 4'b1111;
        bus.i_release = 1'b0;
        model_reset();

        // Reset held low with all channels requesting
        repeat (3) @(posedge clk);
        #1;
        check_dut("reset");
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_first");
        chk("rst_first_valid", 4'(bus.o_grant_valid), 4'd1);
        chk("rst_first_idx",   4'(bus.o_grant_idx),   4'd0);

        // Rotation with all channels requesting
        got.delete();
        got.push_back(int'(bus.o_grant_idx));
        bus.i_release = rel_rule();
        n = 0;
        while (got.size() < 5 && n < 40) begin
            step("rot");
            if (bus.o_grant_new) got.push_back(int'(bus.o_grant_idx));
            bus.i_release = rel_rule();
            n++;
        end
        chk("rot_count", 4'(got.size()), 4'd5);
        for (int k = 0; k < 5 && k < got.size(); k++)
            chk($sformatf("rot_seq%0d", k), 4'(got[k]), 4'(exp_rot[k]));

        // Sparse requests from a fresh pointer
        #2;
        rst_n = 1'b0;
        bus.i_release = 1'b0;
        bus.i_req = 4'b1010;
        #1;
        model_reset();
        check_dut("sparse_rst");
        @(negedge clk);
        rst_n = 1'b1;
        got.delete();
        n = 0;
        while (got.size() < 3 && n < 40) begin
            step("sparse");
            if (bus.o_grant_new) got.push_back(int'(bus.o_grant_idx));
            bus.i_release = rel_rule();
            n++;
        end
        chk("sparse_count", 4'(got.size()), 4'd3);
        for (int k = 0; k < 3 && k < got.size(); k++)
            chk($sformatf("sparse_seq%0d", k), 4'(got[k]), 4'(exp_sparse[k]));
        n = 0;
        while (m_valid && n < 10) begin
            step("sparse_end");
            bus.i_release = rel_rule();
            n++;
        end

        // Hold limit on a lone requester
        bus.i_release = 1'b0;
        bus.i_req = 4'b0100;
        seen = 0;
        n = 0;
        while (!seen && n < 10) begin
            step("tmo_wait");
            seen = bus.o_grant_new;
            n++;
        end
        chk("tmo_granted", 4'(seen), 4'd1);
        n = 1;
        while (bus.o_grant_valid && n < 40) begin
            step("tmo_hold");
            if (bus.o_grant_valid) n++;
        end
        chk("tmo_len", 4'(n), 4'd15);
        chk("tmo_pulse", 4'(bus.o_timeout), 4'd1);
        step("tmo_regrant");
        chk("tmo_regrant_new", 4'(bus.o_grant_new), 4'd1);
        chk("tmo_regrant_idx", 4'(bus.o_grant_idx), 4'd2);

        // Requester drop on the 5th cycle of a grant to channel 3
        bus.i_req = 4'b1000;
        seen = 0;
        n = 0;
        while (!seen && n < 10) begin
            step("drop_wait");
            seen = bus.o_grant_new && (bus.o_grant_idx == 2'd3);
            n++;
        end
        chk("drop_granted", 4'(seen), 4'd1);
        n = 0;
        while (m_held < 5 && n < 10) begin
            step("drop_hold");
            n++;
        end
        bus.i_req = 4'b0000;
        step("drop");
        chk("drop_valid", 4'(bus.o_grant_valid), 4'd0);
        chk("drop_tmo",   4'(bus.o_timeout),     4'd0);

        // Asynchronous reset in the middle of a grant to channel 2
        bus.i_req = 4'b0101;
        seen = 0;
        n = 0;
        while (!seen && n < 20) begin
            step("mid_wait");
            seen = bus.o_grant_new && (bus.o_grant_idx == 2'd2);
            bus.i_release = seen ? 1'b0 : rel_rule();
            n++;
        end
        chk("mid_granted", 4'(seen), 4'd1);
        step("mid_hold");
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 4'(bus.o_grant_valid), 4'd0);
        chk("mid_rst_idx",   4'(bus.o_grant_idx),   4'd0);
        chk("mid_rst_new",   4'(bus.o_grant_new),   4'd0);
        chk("mid_rst_tmo",   4'(bus.o_timeout),     4'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step("mid_after");
        chk("mid_after_new", 4'(bus.o_grant_new), 4'd1);
        chk("mid_after_idx", 4'(bus.o_grant_idx), 4'd0);

        // Randomized traffic with long stable request stretches so the limit also fires
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 11) == 0) bus.i_req = 4'($urandom_range(0, 15));
            bus.i_release = ($urandom_range(0, 9) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
